plru_eviction_engine: RTL and testbench
=======================================

# plru_eviction_engine

Tree pseudo-LRU replacement engine for one cache set. It sits on the policy side of the cache eviction interface: it consumes the controller's hit, miss and allocate notifications and answers each miss with a one-hot `evictionTarget` qualified by `evictionReady`. The victim is found by walking the PLRU tree one level per cycle, so the engine holds a small FSM and per-way state between the controller and the tag/data arrays.

## Interface
- `NUM_WAYS`, default 8: ways per set; a power of two, at least 2.
- `LEVELS`, default $clog2(NUM_WAYS): tree depth L. Derived; never overridden.

- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hit`  in  1  qualifies `hitWay`.
- `hitWay`  in  NUM_WAYS  one-hot way that was hit.
- `miss`  in  1  single-cycle pulse requesting a victim.
- `missWay`  in  NUM_WAYS  carried for interface compatibility; ignored.
- `allocate`  in  1  qualifies `allocateWay`.
- `allocateWay`  in  NUM_WAYS  one-hot way being filled.
- `evictionTarget`  out  NUM_WAYS  one-hot victim; valid only while `evictionReady` is high.
- `evictionReady`  out  1  victim is valid and held stable.

## Operation
- State: tree bits `plru[NUM_WAYS-2:0]`, heap-indexed (node n at bit n-1, root n=1); FSM `IDLE`, `WALK`, `READY`; walk node register; level counter.
- Tree bit meaning: 0 sends the victim search left, 1 sends it right.
- Touch(w), on hit or allocate: every node on w's path is set to point away from w (bit set to 1 if w lies in the left subtree, otherwise 0).
- Hit and allocate in the same cycle: apply the hit touch first, then the allocate touch. Allocate wins on shared nodes.
- Way vectors with more than one bit set: the lowest set index is used. An all-zero vector with its qualifier high does nothing.
- `IDLE` + `miss`: go to `WALK`, node=1, level=0.
- In `WALK`, each cycle: node = 2·node + plru[node-1], level++.
  - When level reaches L-1 on this step, go to `READY`.
  - Register `evictionTarget` = one-hot(node − NUM_WAYS) and set `evictionReady`=1.
- In `READY`:
  - `evictionTarget` and `evictionReady` hold until an allocate or a restart.
  - `allocate` (any way): touch the tree, go to `IDLE`, drive `evictionReady`=0.
  - `hit` on the current target: go to `WALK` from the root and drive `evictionReady`=0.
  - `hit` on any other way: touch the tree only; the target is held.
- Any `hit` or `allocate` during `WALK`: touch the tree and restart the walk from the root (level=0).
- `miss` in `WALK` or `READY`: ignored. Only one request is outstanding at a time.

## Timing
- Reset values: `plru`=0, state `IDLE`, `evictionTarget`=0, `evictionReady`=0. Valid bits are 0 when compiled in.
- `reset` has priority over every input in the same cycle. Reset mid-walk or in `READY` drops `evictionReady` the next cycle, with no residual request.
- Miss latency: `miss` in cycle 0, `evictionReady` high in cycle L+1 (cycle 4 for 8 ways). A restart adds L+1 cycles counted from the restarting cycle.
- Tree touches are visible to a walk step in the next cycle.
- `evictionReady` falls in the cycle after the accepting `allocate`.

## Configuration
- `PLRU_INVALID_FIRST_EN` defined:
  - Adds a per-way `valid` register, set by `allocate` and cleared only by reset.
  - On `miss` in `IDLE` with any way invalid, go directly to `READY` with the lowest-index invalid way. `evictionReady` rises in cycle 1.
  - With all ways valid, the normal walk is used.
- Macro undefined: no valid register exists, and every miss walks the tree.

## Structure
- Package `plru_pkg` holds:
  - the `plru_state_e` enum (`IDLE`, `WALK`, `READY`);
  - the function `onehot_to_idx` (lowest-set-bit priority);
  - the function `idx_to_onehot`.
- Sub-module `plru_tree_touch`: combinational. Inputs are the current tree and a way index; output is the updated tree. It is instantiated twice (hit, then allocate) in series.

## Test plan
- Reset, then `miss` in cycle 0 (macro off) -> `evictionReady`=1 in cycle 4, `evictionTarget`=8'h01. The output stays 0 in cycles 0–3.
- Hits to ways 0..7 in order, then `miss` -> target 8'h01. Then `allocate` way 0 -> `evictionReady`=0 in the next cycle.
- After the previous sequence, hit way 0, then `miss` -> target 8'h10 (way 4).
- In `READY` with target 8'h10, hit way 4 -> ready drops the next cycle and re-asserts 4 cycles later with a new target ≠ 8'h10. A second `miss` during this walk has no effect.
- `reset` asserted in the second `WALK` cycle -> ready stays 0. All outputs are 0 the next cycle, and a new `miss` gives the cycle-4 latency again.
- Macro on: after reset, allocate ways 0 and 1, then `miss` -> `evictionReady` in cycle 1, target 8'h04. Allocate all 8 ways, then `miss` -> walk latency of 4 cycles.

Source files
------------

// File: rtl/plru_pkg.sv
// Shared types and one-hot/index helpers for the tree pseudo-LRU eviction engine.
package plru_pkg;

  localparam int unsigned MAX_WAYS = 256;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    READY
  } plru_state_e;

  // Lowest set bit wins; an all-zero vector maps to index 0.
  function automatic int unsigned onehot_to_idx(input logic [MAX_WAYS-1:0] vec);
    logic [MAX_WAYS-1:0] v;
    logic                found;
    int unsigned         idx;
    v     = vec;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      if (v[0] && !found) begin
        idx   = i;
        found = 1'b1;
      end
      v = v >> 1;
    end
    return idx;
  endfunction

  function automatic logic [MAX_WAYS-1:0] idx_to_onehot(input int unsigned idx);
    return MAX_WAYS'(1) << idx;
  endfunction

endpackage

// File: rtl/plru_tree_touch.sv
// Combinational PLRU touch: points every node on a way's path away from that way.
module plru_tree_touch #(
  parameter int NUM_WAYS = 8,
  parameter int LEVELS   = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] tree,
  input  logic                en,
  input  logic [LEVELS-1:0]   way,
  output logic [NUM_WAYS-2:0] tree_next
);

  logic [NUM_WAYS-1:0] heap;
  logic [LEVELS-1:0]   node;
  logic [LEVELS-1:0]   dir;

  // Heap node n lives at heap[n]; bit 0 is unused padding so node indices fit LEVELS bits.
  always_comb begin
    heap = {tree, 1'b0};
    node = '0;
    dir  = '0;
    if (en) begin
      for (int unsigned k = 0; k < LEVELS; k++) begin
        node       = LEVELS'((NUM_WAYS + 32'(way)) >> (LEVELS - k));
        dir        = way >> (LEVELS - 1 - k);
        heap[node] = ~dir[0];
      end
    end
    tree_next = heap[NUM_WAYS-1:1];
  end

endmodule

// File: rtl/plru_eviction_engine.sv
// Tree pseudo-LRU victim selection for one cache set, walking one tree level per cycle.
// Optional PLRU_INVALID_FIRST_EN: misses pick the lowest invalid way before walking.
module plru_eviction_engine
  import plru_pkg::*;
#(
  parameter int NUM_WAYS = 8,
  parameter int LEVELS   = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hit,
  input  logic [NUM_WAYS-1:0] hitWay,
  input  logic                miss,
  input  logic [NUM_WAYS-1:0] missWay,
  input  logic                allocate,
  input  logic [NUM_WAYS-1:0] allocateWay,
  output logic [NUM_WAYS-1:0] evictionTarget,
  output logic                evictionReady
);

  localparam logic [LEVELS:0]   ROOT       = (LEVELS + 1)'(1);
  localparam logic [LEVELS-1:0] LAST_LEVEL = LEVELS'(LEVELS - 1);

  plru_state_e         state;
  logic [NUM_WAYS-2:0] plru;
  logic [NUM_WAYS-2:0] tree_hit;
  logic [NUM_WAYS-2:0] tree_next;
  logic [NUM_WAYS-1:0] heap;
  logic [LEVELS:0]     node;
  logic [LEVELS:0]     node_step;
  logic [LEVELS-1:0]   level;
  logic [LEVELS-1:0]   hit_idx;
  logic [LEVELS-1:0]   alloc_idx;
  logic [LEVELS-1:0]   tgt_idx;
  logic                hit_en;
  logic                alloc_en;
  logic                unused_miss_way;

  assign unused_miss_way = ^missWay;

  assign hit_en    = hit & (|hitWay);
  assign alloc_en  = allocate & (|allocateWay);
  assign hit_idx   = LEVELS'(onehot_to_idx(MAX_WAYS'(hitWay)));
  assign alloc_idx = LEVELS'(onehot_to_idx(MAX_WAYS'(allocateWay)));
  assign tgt_idx   = LEVELS'(onehot_to_idx(MAX_WAYS'(evictionTarget)));

  // While walking, node < NUM_WAYS, so its low bits index the heap-aligned tree directly.
  assign heap      = {plru, 1'b0};
  assign node_step = {node[LEVELS-1:0], heap[node[LEVELS-1:0]]};

  plru_tree_touch #(.NUM_WAYS(NUM_WAYS), .LEVELS(LEVELS)) u_touch_hit (
    .tree      (plru),
    .en        (hit_en),
    .way       (hit_idx),
    .tree_next (tree_hit)
  );

  plru_tree_touch #(.NUM_WAYS(NUM_WAYS), .LEVELS(LEVELS)) u_touch_alloc (
    .tree      (tree_hit),
    .en        (alloc_en),
    .way       (alloc_idx),
    .tree_next (tree_next)
  );

`ifdef PLRU_INVALID_FIRST_EN
  logic [NUM_WAYS-1:0] valid;
  logic [LEVELS-1:0]   inv_idx;

  assign inv_idx = LEVELS'(onehot_to_idx(MAX_WAYS'(~valid)));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (alloc_en) begin
      valid <= valid | NUM_WAYS'(idx_to_onehot(32'(alloc_idx)));
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      plru           <= '0;
      state          <= IDLE;
      node           <= ROOT;
      level          <= '0;
      evictionTarget <= '0;
      evictionReady  <= 1'b0;
    end else begin
      plru <= tree_next;
      unique case (state)
        IDLE: begin
          if (miss) begin
`ifdef PLRU_INVALID_FIRST_EN
            if (!(&valid)) begin
              state          <= READY;
              evictionTarget <= NUM_WAYS'(idx_to_onehot(32'(inv_idx)));
              evictionReady  <= 1'b1;
            end else begin
              state <= WALK;
              node  <= ROOT;
              level <= '0;
            end
`else
            state <= WALK;
            node  <= ROOT;
            level <= '0;
`endif
          end
        end
        WALK: begin
          if (hit_en || alloc_en) begin
            node  <= ROOT;
            level <= '0;
          end else begin
            node  <= node_step;
            level <= level + LEVELS'(1);
            if (level == LAST_LEVEL) begin
              state          <= READY;
              evictionTarget <= NUM_WAYS'(idx_to_onehot(32'(node_step[LEVELS-1:0])));
              evictionReady  <= 1'b1;
            end
          end
        end
        READY: begin
          if (alloc_en) begin
            state          <= IDLE;
            evictionTarget <= '0;
            evictionReady  <= 1'b0;
          end else if (hit_en && (hit_idx == tgt_idx)) begin
            state          <= WALK;
            node           <= ROOT;
            level          <= '0;
            evictionTarget <= '0;
            evictionReady  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plru_eviction_engine.sv
// Randomized plus directed bench for plru_eviction_engine against a transaction-level PLRU model.
module tb_plru_eviction_engine;

  localparam int NW = 8;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          hit;
  logic [NW-1:0] hitWay;
  logic          miss;
  logic [NW-1:0] missWay;
  logic          allocate;
  logic [NW-1:0] allocateWay;
  logic [NW-1:0] evictionTarget;
  logic          evictionReady;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  plru_eviction_engine #(.NUM_WAYS(NW)) dut (
    .clk            (clk),
    .reset          (reset),
    .hit            (hit),
    .hitWay         (hitWay),
    .miss           (miss),
    .missWay        (missWay),
    .allocate       (allocate),
    .allocateWay    (allocateWay),
    .evictionTarget (evictionTarget),
    .evictionReady  (evictionReady)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: tree bits per heap node (1..NW-1), request mode, remaining walk cycles.
  bit m_tree[NW];
  bit m_valid[NW];
  int m_mode;     // 0 idle, 1 searching, 2 victim offered
  int m_wait;
  int m_victim;
  bit m_ready;

  function automatic int lowest(input logic [NW-1:0] v);
    int r;
    r = -1;
    for (int i = NW - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic void m_touch(input int w);
    int n;
    n = NW + w;
    while (n > 1) begin
      m_tree[n / 2] = (n % 2 == 0);
      n = n / 2;
    end
  endfunction

  function automatic int m_walk();
    int n;
    n = 1;
    for (int k = 0; k < L; k++) n = 2 * n + int'(m_tree[n]);
    return n - NW;
  endfunction

  function automatic void model_step();
    bit th, ta;
    int hi, ai, vic, inv;
    th  = hit && (hitWay != 0);
    ta  = allocate && (allocateWay != 0);
    hi  = lowest(hitWay);
    ai  = lowest(allocateWay);
    vic = m_walk();
    inv = -1;
    for (int i = NW - 1; i >= 0; i--) if (!m_valid[i]) inv = i;
    if (reset) begin
      for (int i = 0; i < NW; i++) begin
        m_tree[i]  = 1'b0;
        m_valid[i] = 1'b0;
      end
      m_mode  = 0;
      m_wait  = 0;
      m_ready = 1'b0;
      return;
    end
    case (m_mode)
      0: if (miss) begin
`ifdef PLRU_INVALID_FIRST_EN
        if (inv >= 0) begin
          m_mode   = 2;
          m_ready  = 1'b1;
          m_victim = inv;
        end else begin
          m_mode = 1;
          m_wait = L;
        end
`else
        m_mode = 1;
        m_wait = L;
`endif
      end
      1: if (th || ta) m_wait = L;
         else begin
           m_wait--;
           if (m_wait == 0) begin
             m_mode   = 2;
             m_ready  = 1'b1;
             m_victim = vic;
           end
         end
      default: if (ta) begin
        m_mode  = 0;
        m_ready = 1'b0;
      end else if (th && hi == m_victim) begin
        m_mode  = 1;
        m_wait  = L;
        m_ready = 1'b0;
      end
    endcase
    if (th) m_touch(hi);
    if (ta) begin
      m_touch(ai);
      m_valid[ai] = 1'b1;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_val("ready", 32'(evictionReady), 32'(m_ready));
    if (m_ready) check_val("target", 32'(evictionTarget), 32'(1) << m_victim);
  endtask

  task automatic idle_inputs();
    reset       = 1'b0;
    hit         = 1'b0;
    hitWay      = '0;
    miss        = 1'b0;
    missWay     = '0;
    allocate    = 1'b0;
    allocateWay = '0;
  endtask

  task automatic do_hit(input int w);
    hit    = 1'b1;
    hitWay = NW'(1) << w;
    cycle();
    hit    = 1'b0;
    hitWay = '0;
  endtask

  task automatic do_alloc(input int w);
    allocate    = 1'b1;
    allocateWay = NW'(1) << w;
    cycle();
    allocate    = 1'b0;
    allocateWay = '0;
  endtask

  // Latency counted in cycles after the launching edge; bounded so a stuck DUT still finishes.
  task automatic wait_ready(output int lat);
    lat = 1;
    while (!evictionReady && lat < 20) begin
      cycle();
      lat++;
    end
  endtask

  task automatic miss_and_wait(output int lat);
    miss    = 1'b1;
    missWay = NW'($urandom);
    cycle();
    miss    = 1'b0;
    wait_ready(lat);
  endtask

  function automatic logic [NW-1:0] rand_vec();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return NW'(1) << $urandom_range(0, NW - 1);
    if (r < 9) return NW'($urandom);
    return '0;
  endfunction

  int lat;

  initial begin
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    check_val("reset_target", 32'(evictionTarget), 32'h0);
    check_val("reset_ready", 32'(evictionReady), 32'h0);
    reset = 1'b0;

`ifndef PLRU_INVALID_FIRST_EN
    miss_and_wait(lat);
    check_val("first_latency", lat, 4);
    check_val("first_target", 32'(evictionTarget), 32'h01);
    do_alloc(0);
    for (int w = 0; w < NW; w++) do_hit(w);
    miss_and_wait(lat);
    check_val("lru_after_hits", 32'(evictionTarget), 32'h01);
    do_alloc(0);
    check_val("ready_drop_alloc", 32'(evictionReady), 32'h0);
    do_hit(0);
    miss_and_wait(lat);
    check_val("victim_way4", 32'(evictionTarget), 32'h10);
    do_hit(4);
    check_val("ready_drop_rehit", 32'(evictionReady), 32'h0);
    miss = 1'b1;
    cycle();
    miss = 1'b0;
    wait_ready(lat);
    check_val("rehit_latency", lat, 3);
    check_val("rehit_differs", 32'(evictionTarget != 8'h10), 32'h1);
    check_val("rehit_target", 32'(evictionTarget), 32'h04);
    do_alloc(2);
    miss = 1'b1;
    cycle();
    miss = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_val("midwalk_reset_target", 32'(evictionTarget), 32'h0);
    check_val("midwalk_reset_ready", 32'(evictionReady), 32'h0);
    miss_and_wait(lat);
    check_val("post_reset_latency", lat, 4);
    do_alloc(0);
`else
    do_alloc(0);
    do_alloc(1);
    miss_and_wait(lat);
    check_val("invalid_latency", lat, 1);
    check_val("invalid_target", 32'(evictionTarget), 32'h04);
    for (int w = 0; w < NW; w++) do_alloc(w);
    miss_and_wait(lat);
    check_val("full_walk_latency", lat, 4);
    do_alloc(0);
`endif

    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 199) == 0);
      hit         = ($urandom_range(0, 3) == 0);
      hitWay      = rand_vec();
      miss        = ($urandom_range(0, 3) == 0);
      missWay     = NW'($urandom);
      allocate    = ($urandom_range(0, 5) == 0);
      allocateWay = rand_vec();
      cycle();
    end
    idle_inputs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
